// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   OP_J / OP_JAL      : primary opcodes of the absolute-jump instructions
//   RESET_PC_DEFAULT   : default byte address the PC is loaded with on reset
//   fetch_state_e      : fetch sequencer states (BOOT, RUN, FAULT)
//   jump_target()      : forms the pseudo-direct j/jal target address
package cpu_pkg;

    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [5:0]  OP_JAL           = 6'b000011;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,  // ROM is reading the reset PC, no instruction yet
        RUN   = 2'd1,  // normal zero-bubble fetch
        FAULT = 2'd2   // bad fetch target seen; frozen until reset
    } fetch_state_e;

    // j/jal keep the top nibble of the sequential PC and replace the rest
    // with the 26-bit word index from the instruction.
    function automatic logic [31:0] jump_target(input logic [3:0]  pc_region,
                                                input logic [25:0] instr_index);
        return {pc_region, instr_index, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority selector and fetch-target check (purely combinational).
//   pc_plus_4    in  : sequential successor of the current PC
//   instr_index  in  : Instruction[25:0] of the current instruction
//   addr_result  in  : branch target from the execute stage
//   zero         in  : execute-stage zero flag
//   read_data_1  in  : rs value, jr target
//   branch/nbranch/jmp/jal/jr in : controller flags
//   next_pc      out : selected target (jr > j/jal > taken branch > PC+4)
//   target_fault out : next_pc is misaligned or beyond the ROM
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = 16384
) (
    input  logic [31:0] pc_plus_4,
    input  logic [25:0] instr_index,
    input  logic [31:0] addr_result,
    input  logic        zero,
    input  logic [31:0] read_data_1,
    input  logic        branch,
    input  logic        nbranch,
    input  logic        jmp,
    input  logic        jal,
    input  logic        jr,
    output logic [31:0] next_pc,
    output logic        target_fault
);

    // One past the last valid byte address; 33 bits so the compare cannot wrap.
    localparam logic [32:0] FETCH_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

    logic branch_taken;

    assign branch_taken = (branch & zero) | (nbranch & ~zero);

    // NOTE: every output of an always_comb gets a default before any branch;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        next_pc = pc_plus_4;
        if (jr) begin
            next_pc = read_data_1;
        end else if (jmp || jal) begin
            next_pc = jump_target(pc_plus_4[31:28], instr_index);
        end else if (branch_taken) begin
            next_pc = addr_result;
        end
    end

    assign target_fault = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= FETCH_LIMIT);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, synchronous ROM addressing,
// next-PC selection, jal link capture and fetch-fault detection.
//   clock, rst_n        : clock, asynchronous active-low reset
//   stall               : hold PC and current instruction
//   imem_addr / imem_rdata : synchronous ROM port (data one clock after addr)
//   Addr_Result, Zero, Read_data_1 : execute-stage results
//   Branch, nBranch, Jmp, Jal, Jr  : controller flags
//   Instruction, pc_out, PC_plus_4 : current instruction, its PC, PC+4
//   link_addr           : return address captured on a taken jal
//   instr_valid         : Instruction corresponds to pc_out
//   fetch_fault         : sticky; set by a misaligned/out-of-range target
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_DEPTH = 16384,
    parameter int          IMEM_AW    = 14
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               stall,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic [31:0]        Addr_Result,
    input  logic               Zero,
    input  logic [31:0]        Read_data_1,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Jr,
    output logic [31:0]        Instruction,
    output logic [31:0]        pc_out,
    output logic [31:0]        PC_plus_4,
    output logic [31:0]        link_addr,
    output logic               instr_valid,
    output logic               fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, link_q;
    logic [31:0]  pc_plus_4, sel_pc, pc_d;
    logic         target_fault, redirect_en, advance, fault_hit;

    assign pc_plus_4 = pc_q + 32'd4;

    next_pc_sel #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_next_pc_sel (
        .pc_plus_4    (pc_plus_4),
        .instr_index  (imem_rdata[25:0]),
        .addr_result  (Addr_Result),
        .zero         (Zero),
        .read_data_1  (Read_data_1),
        .branch       (Branch),
        .nbranch      (nBranch),
        .jmp          (Jmp),
        .jal          (Jal),
        .jr           (Jr),
        .next_pc      (sel_pc),
        .target_fault (target_fault)
    );

    // Flags only matter in RUN without a stall; BOOT, stall and FAULT all
    // re-present the current PC so the ROM re-reads the same word.
    assign redirect_en = (state_q == RUN) && !stall;
    assign advance     = redirect_en && !target_fault;
    assign fault_hit   = redirect_en &&  target_fault;
    assign pc_d        = advance ? sel_pc : pc_q;

    // The ROM is addressed with the PC about to be loaded, so a new PC and its
    // instruction appear together. In reset pc_q is RESET_PC, which covers the
    // reset-time address.
    assign imem_addr   = pc_d[IMEM_AW+1:2];

    // State register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = fault_hit ? FAULT : RUN;
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    // Output logic; FAULT is terminal, so the fault flag stays set until reset.
    always_comb begin
        instr_valid = 1'b0;
        fetch_fault = 1'b0;
        unique case (state_q)
            RUN:     instr_valid = 1'b1;
            FAULT:   fetch_fault = 1'b1;
            default: ;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            link_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
            // jr outranks jal, so the link is only written when jal's target wins.
            if (advance && Jal && !Jr) begin
                link_q <= pc_plus_4;
            end
        end
    end

    assign Instruction = imem_rdata;
    assign pc_out      = pc_q;
    assign PC_plus_4   = pc_plus_4;
    assign link_addr   = link_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 16384;
    localparam int AW    = 14;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   Addr_Result = '0;
    logic          Zero = 1'b0;
    logic [31:0]   Read_data_1 = '0;
    logic          Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0;
    logic [31:0]   Instruction, pc_out, PC_plus_4, link_addr;
    logic          instr_valid, fetch_fault;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (DEPTH),
        .IMEM_AW    (AW)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .Addr_Result (Addr_Result),
        .Zero        (Zero),
        .Read_data_1 (Read_data_1),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Instruction (Instruction),
        .pc_out      (pc_out),
        .PC_plus_4   (PC_plus_4),
        .link_addr   (link_addr),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault)
    );

    always #5 clock = ~clock;

    // Synchronous instruction ROM owned by the bench.
    logic [31:0] rom [DEPTH];
    always @(posedge clock) imem_rdata <= rom[imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc   = 32'd0;
    logic [31:0] m_link = 32'd0;
    bit          m_valid = 1'b0;  // an instruction is being presented
    bit          m_fault = 1'b0;

    function automatic logic [31:0] model_target();
        logic [31:0] seq;
        logic [31:0] word;
        seq  = m_pc + 32'd4;
        word = rom[m_pc[AW+1:2]];
        if (Jr)                                      return Read_data_1;
        if (Jmp || Jal)                              return (seq & 32'hF000_0000) | ({6'd0, word[25:0]} << 2);
        if ((Branch && Zero) || (nBranch && !Zero))  return Addr_Result;
        return seq;
    endfunction

    function automatic bit bad_target(input logic [31:0] t);
        return (t % 4 != 0) || (64'(t) >= 64'(DEPTH) * 4);
    endfunction

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 32'd0;
            m_link  <= 32'd0;
            m_valid <= 1'b0;
            m_fault <= 1'b0;
        end else if (m_fault) begin
            // frozen until reset
        end else if (!m_valid) begin
            m_valid <= 1'b1;
        end else if (!stall) begin
            if (bad_target(model_target())) begin
                m_fault <= 1'b1;
                m_valid <= 1'b0;
            end else begin
                m_pc <= model_target();
                if (Jal && !Jr) m_link <= m_pc + 32'd4;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (rst_n) begin
            check("m.pc_out",      pc_out,            m_pc);
            check("m.PC_plus_4",   PC_plus_4,         m_pc + 32'd4);
            check("m.link_addr",   link_addr,         m_link);
            check("m.instr_valid", 32'(instr_valid),  32'(m_valid));
            check("m.fetch_fault", 32'(fetch_fault),  32'(m_fault));
            if (m_valid) check("m.Instruction", Instruction, rom[m_pc[AW+1:2]]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic jr, input logic jmp, input logic jal,
                        input logic br, input logic nbr, input logic z,
                        input logic [31:0] addr, input logic [31:0] rd1);
        stall = s; Jr = jr; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr; Zero = z;
        Addr_Result = addr; Read_data_1 = rd1;
        @(negedge clock);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic do_jr(input logic [31:0] tgt);
        step(0, 1, 0, 0, 0, 0, 0, 32'd0, tgt);
    endtask

    task automatic reset_release();
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        check("boot instr_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'hA500_0000 | 32'(i);
        rom[0]         = 32'h2008_0005;
        rom[8]         = {OP_JAL, 26'h000_0040};  // at 0x20 -> 0x100
        rom[12]        = {OP_J,   26'h000_0050};  // at 0x30 -> 0x140
        rom[DEPTH - 1] = 32'hCAFE_F00D;           // last word, 0xFFFC

        // Reset state
        repeat (2) @(negedge clock);
        check("reset imem_addr",   32'(imem_addr),   32'd0);
        check("reset pc_out",      pc_out,           32'd0);
        check("reset link_addr",   link_addr,        32'd0);
        check("reset fetch_fault", 32'(fetch_fault), 32'd0);
        reset_release();

        // First valid fetch and straight-line flow
        idle();
        check("t1 pc_out",      pc_out,           32'd0);
        check("t1 Instruction", Instruction,      32'h2008_0005);
        check("t1 PC_plus_4",   PC_plus_4,        32'd4);
        check("t1 instr_valid", 32'(instr_valid), 32'd1);
        idle(); check("t2 pc 4", pc_out, 32'h4);
        idle(); check("t2 pc 8", pc_out, 32'h8);

        // Stall with Jmp asserted: nothing moves
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
            check("stall pc",          pc_out,      32'h8);
            check("stall Instruction", Instruction, 32'hA500_0002);
            check("stall link",        link_addr,   32'd0);
        end
        idle(); check("t2 pc C",  pc_out, 32'hC);
        idle(); check("t2 pc 10", pc_out, 32'h10);

        // Branches
        step(0, 0, 0, 0, 1, 0, 1, 32'h40, 32'd0); check("beq taken",   pc_out, 32'h40);
        do_jr(32'h10);                            check("jr to 10",    pc_out, 32'h10);
        step(0, 0, 0, 0, 1, 0, 0, 32'h40, 32'd0); check("beq not tkn", pc_out, 32'h14);
        step(0, 0, 0, 0, 0, 1, 0, 32'h40, 32'd0); check("bne taken",   pc_out, 32'h40);

        // jal / jr
        do_jr(32'h20);                            check("jr to 20",    pc_out, 32'h20);
        step(0, 0, 0, 1, 0, 0, 0, 32'd0, 32'd0);
        check("jal pc",   pc_out,    32'h100);
        check("jal link", link_addr, 32'h24);
        idle();                                   check("pc 104",      pc_out, 32'h104);
        do_jr(32'h24);
        check("jr return pc",   pc_out,    32'h24);
        check("jr return link", link_addr, 32'h24);

        // Priority: jr over jmp over branch; beq|bne with Zero=0 takes the branch
        step(0, 1, 1, 0, 1, 0, 1, 32'h80, 32'h30); check("prio jr",   pc_out, 32'h30);
        step(0, 0, 1, 0, 1, 0, 1, 32'h80, 32'd0);  check("prio jmp",  pc_out, 32'h140);
        step(0, 0, 0, 0, 1, 1, 0, 32'h200, 32'd0); check("beq|bne",   pc_out, 32'h200);

        // Misaligned jr target -> fault, frozen
        do_jr(32'h0000_0042);
        check("fault flag",  32'(fetch_fault), 32'd1);
        check("fault valid", 32'(instr_valid), 32'd0);
        check("fault pc",    pc_out,           32'h200);
        do_jr(32'h80);
        step(0, 0, 0, 1, 0, 0, 0, 32'd0, 32'd0);
        check("fault held pc",   pc_out,    32'h200);
        check("fault held link", link_addr, 32'h24);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("async pc_out",    pc_out,           32'd0);
        check("async fault",     32'(fetch_fault), 32'd0);
        check("async imem_addr", 32'(imem_addr),   32'd0);
        check("async link",      link_addr,        32'd0);
        reset_release();
        idle(); check("reboot pc", pc_out, 32'd0);

        // Range boundary: last word is fine, the next one faults
        do_jr(32'h0000_FFFC);
        check("last word pc",    pc_out,      32'h0000_FFFC);
        check("last word instr", Instruction, 32'hCAFE_F00D);
        idle();
        check("range fault",    32'(fetch_fault), 32'd1);
        check("range fault pc", pc_out,           32'h0000_FFFC);

        // Faulting jal target must not write the link register
        rst_n = 1'b0;
        @(negedge clock);
        reset_release();
        idle();
        step(0, 0, 0, 1, 0, 0, 0, 32'd0, 32'd0);  // target 0x0020_0014
        check("jal fault flag", 32'(fetch_fault), 32'd1);
        check("jal fault link", link_addr,        32'd0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the execute stage. It holds the program counter and drives a synchronous instruction ROM. It presents the current instruction and PC+4 to the decoder and execute stage. It consumes the execute stage's Addr_Result, Zero and Read_data_1, plus the controller's branch/jump flags, to select the next PC. It also captures the jal link address and flags misaligned or out-of-range fetch targets.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
IMEM_DEPTH, 16384, instruction ROM depth in 32-bit words; a power of two.
IMEM_AW, 14, ROM word-address width, equal to log2(IMEM_DEPTH).

Ports:
clock  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
stall  in  1  hold PC and current instruction this cycle.
imem_addr  out  IMEM_AW  word address to the synchronous ROM.
imem_rdata  in  32  ROM data; valid one clock after imem_addr.
Addr_Result  in  32  branch target byte address from the execute stage.
Zero  in  1  execute-stage zero flag.
Read_data_1  in  32  rs value, used as the jr target.
Branch  in  1  beq.
nBranch  in  1  bne.
Jmp  in  1  j.
Jal  in  1  jal.
Jr  in  1  jr.
Instruction  out  32  instruction at pc_out.
pc_out  out  32  current PC.
PC_plus_4  out  32  pc_out + 4.
link_addr  out  32  return address captured on jal.
instr_valid  out  1  Instruction corresponds to pc_out.
fetch_fault  out  1  sticky fault flag.

Behaviour:
- Reset (asynchronous, active-low):
  - pc = RESET_PC; link_addr = 0; fetch_fault = 0; instr_valid = 0; state = BOOT.
  - imem_addr = RESET_PC[IMEM_AW+1:2] while rst_n is low.
- States:
  - BOOT: one cycle; ROM is reading RESET_PC. Next state is RUN, with instr_valid = 1 from the next cycle.
  - RUN: normal fetch.
  - FAULT: terminal. PC is frozen, instr_valid = 0, and only reset exits.
- Instruction = imem_rdata, passed through combinationally. imem_addr is driven from next_pc, so a new PC and its instruction appear in the same cycle; fetch is zero-bubble.
- next_pc in RUN with stall = 0 and instr_valid = 1, in priority order:
  1. Jr: Read_data_1.
  2. Jmp or Jal: {PC_plus_4[31:28], Instruction[25:0], 2'b00}.
  3. (Branch & Zero) | (nBranch & ~Zero): Addr_Result.
  4. Otherwise: PC_plus_4.
- Multiple jump/branch flags asserted together are resolved by the priority above, with no error.
- Jal: link_addr <= PC_plus_4 on the same edge the PC takes the jump target. link_addr holds otherwise.
- Stall or BOOT: next_pc = pc and imem_addr = pc word address, so the ROM re-reads and Instruction stays stable. All flags are ignored; link_addr does not update.
- Fault: a selected next_pc with next_pc[1:0] != 0, or with next_pc >= IMEM_DEPTH*4, is a fault.
  - On that edge: fetch_fault <= 1, state <= FAULT, pc is not updated.
  - In FAULT: imem_addr = pc, and all inputs are ignored.
- PC arithmetic is modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0 and is then range-checked like any other target.
- A reset assertion in any state (including mid-stall or FAULT) forces the reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_J = 6'b000010 and OP_JAL = 6'b000011;
  - the fetch state enum (BOOT, RUN, FAULT);
  - the RESET_PC default.
- One natural sub-module, next_pc_sel: purely combinational priority mux plus the fault check. It outputs next_pc and target_fault.
- The FSM, PC register and link register stay in ifetch_unit.

Test Plan:
1. Reset release with the ROM preloaded with word[0] = 0x2008_0005 -> BOOT cycle has instr_valid = 0. The next cycle has pc_out = 0, Instruction = 0x2008_0005, PC_plus_4 = 4, instr_valid = 1.
2. Straight-line fetch for 4 cycles -> pc_out = 0, 4, 8, 0xC with matching ROM words each cycle and no bubbles.
3. beq at pc 0x10 with Branch = 1, Zero = 1, Addr_Result = 0x40 -> next pc_out = 0x40. Repeating with Zero = 0 -> 0x14. bne with Zero = 0 -> 0x40.
4. jal at pc 0x20 with Instruction[25:0] = 0x40 -> pc_out = 0x100 and link_addr = 0x24. A later jr with Read_data_1 = 0x24 -> pc_out = 0x24, link_addr unchanged.
5. stall high for 3 cycles at pc 0x8 with Jmp = 1 -> pc_out stays 0x8, Instruction stable, link_addr unchanged. Fetch resumes from 0xC once stall drops (with Jmp = 0).
6. jr with Read_data_1 = 0x0000_0042 -> fetch_fault = 1, instr_valid = 0, pc_out frozen at the jr address. Asserting rst_n low mid-cycle -> pc_out = RESET_PC and fetch_fault = 0 immediately.
